// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes,
// ALU-op codes, mux select encodings, FSM states and the Moore control word.
package mips_ctrl_pkg;

    // Opcode field values
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation codes
    localparam logic [2:0] ALOP_ADD   = 3'b010;
    localparam logic [2:0] ALOP_SUB   = 3'b110;
    localparam logic [2:0] ALOP_RTYPE = 3'b111;

    // ALU B-input select
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        ADDIEX = 4'd8,
        ADDIWB = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    // Control signals that depend only on the FSM state
    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       memreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alop;
    } ctrl_t;

    // Moore decode of a state into its control word; unlisted signals stay 0
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memread = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.alop    = ALOP_ADD;
                c.pcsrc   = PCSRC_ALU;
            end
            DECODE: begin
                c.alusrcb = SRCB_IMMSH2;
                c.alop    = ALOP_ADD;
            end
            MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.alop    = ALOP_ADD;
            end
            MEMRD: begin
                c.memread = 1'b1;
                c.iord    = 1'b1;
            end
            MEMWB: begin
                c.regwrite = 1'b1;
                c.memreg   = 1'b1;
            end
            MEMWR: begin
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_RT;
                c.alop    = ALOP_RTYPE;
            end
            ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = 1'b1;
            end
            ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                c.alop    = ALOP_ADD;
            end
            ADDIWB: begin
                c.regwrite = 1'b1;
            end
            BRANCH: begin
                c.alusrca     = 1'b1;
                c.alusrcb     = SRCB_RT;
                c.alop        = ALOP_SUB;
                c.pcwritecond = 1'b1;
                c.pcsrc       = PCSRC_ALUOUT;
            end
            JUMP: begin
                c.pcwrite = 1'b1;
                c.pcsrc   = PCSRC_JUMP;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-handshake watchdog: counts consecutive not-ready cycles while a
// memory step is active and flags the cycle in which the wait budget runs out.
module mem_watchdog #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] count;

    // Count stalled cycles; any ready or leaving the wait state restarts the count
    always_ff @(posedge clk) begin
        if (rst || !active || ready) begin
            count <= '0;
        end else begin
            count <= count + TO_W'(1);
        end
    end

    // Expiry fires on the TIMEOUT-th stalled cycle; ready in that cycle wins
    assign expired = active && !ready && (count == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath controls, flags illegal opcodes, halts on a
// memory timeout and counts retired instructions.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALOP_W  = 3,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   op,
    input  logic              mem_ready,
    output logic              pcwrite,
    output logic              pcwritecond,
    output logic              iord,
    output logic              memread,
    output logic              memwrite,
    output logic              irwrite,
    output logic              memreg,
    output logic              regdst,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic [ALOP_W-1:0] alop,
    output logic              illegal_op,
    output logic              fault,
    output logic [CNT_W-1:0]  instr_count,
    output logic [3:0]        state_o
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_q;
    logic   retire;
    logic   wd_active;
    logic   wd_expired;
    logic   fetch_done;

    logic is_rtype, is_lw, is_sw, is_beq, is_addi, is_j, legal_op;

    assign is_rtype = (op == OP_W'(OP_RTYPE));
    assign is_lw    = (op == OP_W'(OP_LW));
    assign is_sw    = (op == OP_W'(OP_SW));
    assign is_beq   = (op == OP_W'(OP_BEQ));
    assign is_addi  = (op == OP_W'(OP_ADDI));
    assign is_j     = (op == OP_W'(OP_J));
    assign legal_op = is_rtype | is_lw | is_sw | is_beq | is_addi | is_j;

    assign wd_active = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

    mem_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .active  (wd_active),
        .ready   (mem_ready),
        .expired (wd_expired)
    );

    // Next-state selection and retirement detection
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                if (wd_expired)     state_next = HALT;
                else if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                if (is_lw || is_sw) state_next = MEMADR;
                else if (is_rtype)  state_next = EXEC;
                else if (is_beq)    state_next = BRANCH;
                else if (is_addi)   state_next = ADDIEX;
                else if (is_j)      state_next = JUMP;
                else                state_next = FETCH;
            end
            MEMADR: state_next = is_sw ? MEMWR : MEMRD;
            MEMRD: begin
                if (wd_expired)     state_next = HALT;
                else if (mem_ready) state_next = MEMWB;
            end
            MEMWR: begin
                if (wd_expired) begin
                    state_next = HALT;
                end else if (mem_ready) begin
                    state_next = FETCH;
                    retire     = 1'b1;
                end
            end
            EXEC:   state_next = ALUWB;
            ADDIEX: state_next = ADDIWB;
            MEMWB, ALUWB, ADDIWB, BRANCH, JUMP: begin
                state_next = FETCH;
                retire     = 1'b1;
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    // State, Moore control word (decoded from the upcoming state so it is
    // registered yet aligned with the state), sticky fault and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            ctrl_q      <= decode_state(FETCH);
            fault       <= 1'b0;
            instr_count <= '0;
        end else begin
            state  <= state_next;
            ctrl_q <= decode_state(state_next);
            if (wd_expired) begin
                fault <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    // Instruction fetch completes in the ready cycle: load IR and PC+4 then
    assign fetch_done = (state == FETCH) && mem_ready;

    assign irwrite     = fetch_done;
    assign pcwrite     = ctrl_q.pcwrite | fetch_done;
    assign pcwritecond = ctrl_q.pcwritecond;
    assign iord        = ctrl_q.iord;
    assign memread     = ctrl_q.memread;
    assign memwrite    = ctrl_q.memwrite;
    assign memreg      = ctrl_q.memreg;
    assign regdst      = ctrl_q.regdst;
    assign regwrite    = ctrl_q.regwrite;
    assign alusrca     = ctrl_q.alusrca;
    assign alusrcb     = ctrl_q.alusrcb;
    assign pcsrc       = ctrl_q.pcsrc;
    assign alop        = ALOP_W'(ctrl_q.alop);
    assign illegal_op  = (state == DECODE) && !legal_op;
    assign state_o     = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, two
// hand-written corner sequences and randomized traffic against a path-based
// reference model.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  op = '0;
    logic        mem_ready = 1'b0;
    logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic        memreg, regdst, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alop;
    logic        illegal_op, fault;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    int unsigned tests = 0;
    int unsigned fails = 0;

    multicycle_control #(
        .OP_W    (6),
        .ALOP_W  (3),
        .TIMEOUT (TO),
        .TO_W    (5),
        .CNT_W   (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .mem_ready   (mem_ready),
        .pcwrite     (pcwrite),
        .pcwritecond (pcwritecond),
        .iord        (iord),
        .memread     (memread),
        .memwrite    (memwrite),
        .irwrite     (irwrite),
        .memreg      (memreg),
        .regdst      (regdst),
        .regwrite    (regwrite),
        .alusrca     (alusrca),
        .alusrcb     (alusrcb),
        .pcsrc       (pcsrc),
        .alop        (alop),
        .illegal_op  (illegal_op),
        .fault       (fault),
        .instr_count (instr_count),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Expected control word, one field per datapath control
    typedef struct packed {
        logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
        logic       memreg, regdst, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alop;
    } ctl_t;

    function automatic ctl_t exp_ctl(input state_t st, input logic rdy);
        ctl_t c;
        c = '0;
        case (st)
            FETCH:  begin c.memread = 1; c.alusrcb = 2'b01; c.alop = 3'b010;
                          c.irwrite = rdy; c.pcwrite = rdy; end
            DECODE: begin c.alusrcb = 2'b11; c.alop = 3'b010; end
            MEMADR: begin c.alusrca = 1; c.alusrcb = 2'b10; c.alop = 3'b010; end
            MEMRD:  begin c.memread = 1; c.iord = 1; end
            MEMWB:  begin c.regwrite = 1; c.memreg = 1; end
            MEMWR:  begin c.memwrite = 1; c.iord = 1; end
            EXEC:   begin c.alusrca = 1; c.alop = 3'b111; end
            ALUWB:  begin c.regwrite = 1; c.regdst = 1; end
            ADDIEX: begin c.alusrca = 1; c.alusrcb = 2'b10; c.alop = 3'b010; end
            ADDIWB: begin c.regwrite = 1; end
            BRANCH: begin c.alusrca = 1; c.alop = 3'b110; c.pcwritecond = 1;
                          c.pcsrc = 2'b01; end
            JUMP:   begin c.pcwrite = 1; c.pcsrc = 2'b10; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [16:0] dut_ctl();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                memreg, regdst, regwrite, alusrca, alusrcb, pcsrc, alop};
    endfunction

    function automatic logic is_legal(input logic [5:0] o);
        return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each instruction is a list of steps chosen at decode;
    // wait steps stall on ready and count towards the timeout budget.
    state_t      m_st = FETCH;
    state_t      m_path[$];
    int unsigned m_wait = 0;
    logic [31:0] m_cnt = '0;
    logic        m_fault = 1'b0;
    bit          m_valid = 1'b0;

    task automatic model_step();
        if (rst) begin
            m_st = FETCH; m_wait = 0; m_cnt = '0; m_fault = 1'b0;
            m_path.delete(); m_valid = 1'b1;
        end else if (!m_valid || m_st == HALT) begin
        end else if ((m_st == FETCH || m_st == MEMRD || m_st == MEMWR) && !mem_ready) begin
            m_wait++;
            if (m_wait == TO) begin
                m_st = HALT; m_fault = 1'b1; m_wait = 0; m_path.delete();
            end
        end else begin
            m_wait = 0;
            if (m_st == FETCH) begin
                m_st = DECODE;
            end else if (m_st == DECODE) begin
                m_path.delete();
                case (op)
                    6'b100011: begin m_path.push_back(MEMADR); m_path.push_back(MEMRD);
                                     m_path.push_back(MEMWB); end
                    6'b101011: begin m_path.push_back(MEMADR); m_path.push_back(MEMWR); end
                    6'b000000: begin m_path.push_back(EXEC); m_path.push_back(ALUWB); end
                    6'b000100: m_path.push_back(BRANCH);
                    6'b001000: begin m_path.push_back(ADDIEX); m_path.push_back(ADDIWB); end
                    6'b000010: m_path.push_back(JUMP);
                    default: ;
                endcase
                m_st = (m_path.size() == 0) ? FETCH : m_path.pop_front();
            end else if (m_path.size() == 0) begin
                m_st = FETCH;
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_st = m_path.pop_front();
            end
        end
    endtask

    // Drive inputs after the edge, then compare outputs against the model
    task automatic apply(input logic r, input logic [5:0] o, input logic rdy);
        ctl_t e;
        rst = r; op = o; mem_ready = rdy;
        #2;
        if (m_valid) begin
            e = exp_ctl(m_st, rdy);
            chk("state", 32'(state_o), 32'(m_st));
            chk("ctrl", 32'(dut_ctl()), 32'(e));
            chk("instr_count", instr_count, m_cnt);
            chk("fault", 32'(fault), 32'(m_fault));
            chk("illegal_op", 32'(illegal_op), 32'((m_st == DECODE) && !is_legal(o)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [5:0]  o;
        logic        rdy;
        state_t      st;
        logic [31:0] cnt;
        logic        flt;
        logic        ill;
        logic [4:0]  strb;   // {irwrite, regwrite, memreg, memwrite, iord}
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [5:0] legal_ops[6];
        logic [5:0] cur_op;
        int unsigned stall_heavy;
        logic rdy, r;

        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

        // LW, R-type, BEQ, J, SW with stalls, illegal opcode, ADDI
        vecs.push_back('{0, 6'b100011, 1, FETCH,  0, 0, 0, 5'b10000});
        vecs.push_back('{0, 6'b100011, 1, DECODE, 0, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b100011, 1, MEMADR, 0, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b100011, 1, MEMRD,  0, 0, 0, 5'b00001});
        vecs.push_back('{0, 6'b100011, 1, MEMWB,  0, 0, 0, 5'b01100});
        vecs.push_back('{0, 6'b000000, 1, FETCH,  1, 0, 0, 5'b10000});
        vecs.push_back('{0, 6'b000000, 1, DECODE, 1, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b000000, 1, EXEC,   1, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b000000, 1, ALUWB,  1, 0, 0, 5'b01000});
        vecs.push_back('{0, 6'b000100, 1, FETCH,  2, 0, 0, 5'b10000});
        vecs.push_back('{0, 6'b000100, 1, DECODE, 2, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b000100, 1, BRANCH, 2, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b000010, 1, FETCH,  3, 0, 0, 5'b10000});
        vecs.push_back('{0, 6'b000010, 1, DECODE, 3, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b000010, 1, JUMP,   3, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b101011, 1, FETCH,  4, 0, 0, 5'b10000});
        vecs.push_back('{0, 6'b101011, 1, DECODE, 4, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b101011, 0, MEMADR, 4, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b101011, 0, MEMWR,  4, 0, 0, 5'b00011});
        vecs.push_back('{0, 6'b101011, 0, MEMWR,  4, 0, 0, 5'b00011});
        vecs.push_back('{0, 6'b101011, 0, MEMWR,  4, 0, 0, 5'b00011});
        vecs.push_back('{0, 6'b101011, 1, MEMWR,  4, 0, 0, 5'b00011});
        vecs.push_back('{0, 6'b111111, 1, FETCH,  5, 0, 0, 5'b10000});
        vecs.push_back('{0, 6'b111111, 1, DECODE, 5, 0, 1, 5'b00000});
        vecs.push_back('{0, 6'b001000, 1, FETCH,  5, 0, 0, 5'b10000});
        vecs.push_back('{0, 6'b001000, 1, DECODE, 5, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b001000, 1, ADDIEX, 5, 0, 0, 5'b00000});
        vecs.push_back('{0, 6'b001000, 1, ADDIWB, 5, 0, 0, 5'b01000});

        // Reset
        apply(1, 6'b0, 0); tick();
        apply(1, 6'b0, 0);
        chk("reset_state", 32'(state_o), 32'(FETCH));
        chk("reset_count", instr_count, 32'd0);
        chk("reset_fault", 32'(fault), 32'd0);
        tick();

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].r, vecs[i].o, vecs[i].rdy);
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(vecs[i].st));
            chk($sformatf("vec%0d_count", i), instr_count, vecs[i].cnt);
            chk($sformatf("vec%0d_fault", i), 32'(fault), 32'(vecs[i].flt));
            chk($sformatf("vec%0d_illegal", i), 32'(illegal_op), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_strobes", i),
                32'({irwrite, regwrite, memreg, memwrite, iord}), 32'(vecs[i].strb));
            tick();
        end

        // Reset while an LW is waiting in MEMRD
        apply(0, 6'b100011, 1);
        chk("midrst_pre_count", instr_count, 32'd6);
        tick();
        apply(0, 6'b100011, 1); tick();
        apply(0, 6'b100011, 0); tick();
        apply(0, 6'b100011, 0);
        chk("midrst_in_memrd", 32'(state_o), 32'(MEMRD));
        tick();
        apply(1, 6'b100011, 0); tick();

        // Fetch starved of ready: halt after TO cycles, sticky fault
        for (int k = 0; k < int'(TO); k++) begin
            apply(0, 6'b100011, 0);
            if (k == 0) begin
                chk("midrst_state", 32'(state_o), 32'(FETCH));
                chk("midrst_count", instr_count, 32'd0);
                chk("midrst_ctrl", 32'(dut_ctl()), 32'(17'b0001000000_01_00_010));
            end
            chk("to_irwrite", 32'(irwrite), 32'd0);
            chk("to_fault_early", 32'(fault), 32'd0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            apply(0, 6'b100011, 1);
            chk("to_halt_state", 32'(state_o), 32'(HALT));
            chk("to_halt_fault", 32'(fault), 32'd1);
            chk("to_halt_irwrite", 32'(irwrite), 32'd0);
            tick();
        end
        apply(1, 6'b100011, 0); tick();
        apply(0, 6'b100011, 0);
        chk("to_recover_state", 32'(state_o), 32'(FETCH));
        chk("to_recover_fault", 32'(fault), 32'd0);
        tick();

        // Randomized traffic against the model
        cur_op = 6'b100011;
        stall_heavy = 0;
        for (int n = 0; n < 2000; n++) begin
            if (m_st == FETCH) begin
                if ($urandom_range(0, 7) < 6) cur_op = legal_ops[$urandom_range(0, 5)];
                else                          cur_op = 6'($urandom_range(0, 63));
                stall_heavy = ($urandom_range(0, 7) == 0) ? 1 : 0;
            end
            if (stall_heavy != 0) rdy = ($urandom_range(0, 9) == 0);
            else                  rdy = ($urandom_range(0, 3) != 0);
            r = ((m_st == HALT) && ($urandom_range(0, 3) == 0)) ||
                ($urandom_range(0, 299) == 0);
            apply(r, cur_op, rdy);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
